// File: rtl/regfile_write_arbiter.sv
// Write-port owner for RegisterFile. After reset it can zero-fill registers
// 1..2^ADDR_WIDTH-1. It then shares the port round-robin between ALU
// writeback (req0) and memory/load writeback (req1) with valid/ready handshakes.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  grant_id,
  output logic                  init_done,
  output logic [15:0]           conflict_count
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;
  localparam state_t RESET_STATE = INIT_ON_RESET ? INIT : RUN;

  state_t                  state;
  state_t                  nextState;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    rrPtr;
  logic                    inRun;
  logic                    bothValid;
  logic                    grant0;
  logic                    grant1;
  logic                    accept;
  logic                    winner;
  logic [ADDR_WIDTH-1:0]   winAddr;
  logic [DATA_WIDTH-1:0]   winData;

  // State register: INIT while zero-filling, RUN once arbitration is live.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= RESET_STATE;
    else        state <= nextState;
  end

  // Next state and round-robin grant. Ready is gated by reset as well, so
  // with INIT_ON_RESET=0 (reset state RUN) neither ready rises during reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    nextState = state;
    inRun     = 1'b0;
    bothValid = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    accept    = 1'b0;
    winner    = 1'b0;
    winAddr   = req0_addr;
    winData   = req0_data;

    if (state == INIT && cnt == LAST_REG) nextState = RUN;

    inRun     = (state == RUN) && reset;
    bothValid = req0_valid && req1_valid;
    grant0    = inRun && req0_valid && (!req1_valid || !rrPtr);
    grant1    = inRun && req1_valid && (!req0_valid ||  rrPtr);
    accept    = grant0 || grant1;
    winner    = grant1;
    if (grant1) begin
      winAddr = req1_addr;
      winData = req1_data;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Write-port datapath: zero-fill sequence in INIT, registered accepted request in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt            <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      rrPtr          <= 1'b0;
      regWrite       <= 1'b0;
      writeReg       <= '0;
      writeData      <= '0;
      grant_id       <= 1'b0;
      conflict_count <= '0;
      init_done      <= ~INIT_ON_RESET;
    end else if (state == INIT) begin
      regWrite  <= 1'b1;
      writeReg  <= cnt;
      writeData <= '0;
      cnt       <= cnt + 1'b1;
      if (cnt == LAST_REG) init_done <= 1'b1;
    end else begin
      if (bothValid && conflict_count != 16'hFFFF)
        conflict_count <= conflict_count + 16'd1;
      if (accept) begin
        // Register 0 is hardwired: the request is consumed but no strobe is issued.
        regWrite  <= (winAddr != '0);
        writeReg  <= winAddr;
        writeData <= winData;
        grant_id  <= winner;
        rrPtr     <= ~winner;
      end else begin
        regWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by randomized
// requesters, checked each cycle against a behavioural model of the write port.
module tb_regfile_write_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          rdy0, rdy1, regWrite, grantId, initDone;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [15:0]   conflictCount;

  logic          rdy0B, rdy1B, regWriteB, grantIdB, initDoneB;
  logic [AW-1:0] writeRegB;
  logic [DW-1:0] writeDataB;
  logic [15:0]   conflictCountB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .grant_id(grantId), .init_done(initDone), .conflict_count(conflictCount)
  );

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b0)) dutNoInit (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0B),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1B),
    .regWrite(regWriteB), .writeReg(writeRegB), .writeData(writeDataB),
    .grant_id(grantIdB), .init_done(initDoneB), .conflict_count(conflictCountB)
  );

  // Behavioural model: zero-fill progress, preferred source, expected port outputs.
  int            initWritten;
  int            prefer;
  int            conflicts;
  logic          expRw;
  logic [AW-1:0] expWr;
  logic [DW-1:0] expWd;
  logic          expGid;
  logic          expInit;
  logic          acc0, acc1;
  logic          p0, p1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    initWritten = 0;
    prefer      = 0;
    conflicts   = 0;
    expRw       = 1'b0;
    expWr       = '0;
    expWd       = '0;
    expGid      = 1'b0;
    expInit     = 1'b0;
    acc0        = 1'b0;
    acc1        = 1'b0;
  endtask

  task automatic checkOutputs(input string phase);
    check({phase, " regWrite"},       32'(regWrite),      32'(expRw));
    check({phase, " writeReg"},       32'(writeReg),      32'(expWr));
    check({phase, " writeData"},      writeData,          expWd);
    check({phase, " grant_id"},       32'(grantId),       32'(expGid));
    check({phase, " init_done"},      32'(initDone),      32'(expInit));
    check({phase, " conflict_count"}, 32'(conflictCount), 32'(conflicts));
  endtask

  // One clock of the main DUT: readys checked at the negedge, registered outputs #1 after the posedge.
  task automatic cycle(input string phase);
    bit            run;
    bit            both;
    int            win;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    run  = (initWritten == NREG - 1);
    both = v0 && v1;
    win  = -1;
    if (run) begin
      if (both)    win = prefer;
      else if (v0) win = 0;
      else if (v1) win = 1;
    end
    wa = (win == 1) ? a1 : a0;
    wd = (win == 1) ? d1 : d0;
    check({phase, " req0_ready"}, 32'(rdy0), 32'(win == 0));
    check({phase, " req1_ready"}, 32'(rdy1), 32'(win == 1));
    acc0 = (win == 0);
    acc1 = (win == 1);
    @(posedge clk);
    #1;
    if (!run) begin
      initWritten++;
      expRw   = 1'b1;
      expWr   = AW'(initWritten);
      expWd   = '0;
      expInit = (initWritten == NREG - 1);
    end else begin
      if (both && conflicts < 65535) conflicts++;
      if (win >= 0) begin
        expRw  = (wa != '0);
        expWr  = wa;
        expWd  = wd;
        expGid = (win == 1);
        prefer = 1 - win;
      end else begin
        expRw = 1'b0;
      end
    end
    checkOutputs(phase);
  endtask

  // Asserts reset at the current time (caller sits #1 after a posedge) and checks the immediate clear.
  task automatic assertReset();
    reset = 1'b0;
    p0 = 1'b0; p1 = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    #1;
    modelReset();
    checkOutputs("reset");
    check("reset req0_ready", 32'(rdy0), 32'd0);
    check("reset req1_ready", 32'(rdy1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic driveRandom();
    if (acc0) p0 = 1'b0;
    if (acc1) p1 = 1'b0;
    if (!p0 && $urandom_range(0, 99) < 60) begin
      p0 = 1'b1;
      a0 = AW'($urandom);
      d0 = $urandom;
    end
    if (!p1 && $urandom_range(0, 99) < 60) begin
      p1 = 1'b1;
      a1 = AW'($urandom);
      d1 = $urandom;
    end
    v0 = p0;
    v1 = p1;
  endtask

  initial begin
    int grants0;
    int grants1;
    logic [3:0] expSeq;
    logic [3:0] gotSeq;

    modelReset();
    p0 = 1'b0; p1 = 1'b0;
    #2;
    assertReset();

    // Zero-fill with no requests, then one idle RUN cycle.
    for (int i = 0; i < NREG - 1; i++) cycle("init");
    cycle("idle");

    // req0 alone.
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    cycle("req0 only");
    v0 = 1'b0;
    cycle("req0 after");

    // req1 writing register 0: consumed, no strobe; leaves req0 preferred.
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h12345678;
    cycle("req1 reg0");
    v1 = 1'b0;
    cycle("idle2");

    // Both held for four cycles: grants alternate starting with req0.
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h0000000A;
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h0000000B;
    grants0 = 0; grants1 = 0; gotSeq = '0;
    expSeq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle("both");
      gotSeq[i] = grantId;
      if (grantId) grants1++; else grants0++;
    end
    v0 = 1'b0; v1 = 1'b0;
    check("both grant order", 32'(gotSeq), 32'(expSeq));
    check("both req0 grants", grants0, 2);
    check("both req1 grants", grants1, 2);
    check("both conflict_count", 32'(conflictCount), 32'd4);

    // Reset in the cycle after an accept, then the fill restarts at register 1.
    v0 = 1'b1; a0 = 5'd9; d0 = 32'hCAFEF00D;
    cycle("pre-reset");
    v0 = 1'b0;
    assertReset();
    cycle("refill first");

    // Randomized traffic; each round starts from reset with requests pending during INIT.
    for (int r = 0; r < 4; r++) begin
      if (r > 0) assertReset();
      for (int c = 0; c < 400; c++) begin
        driveRandom();
        cycle("random");
      end
    end

    // INIT_ON_RESET=0 instance: RUN straight from reset.
    v0 = 1'b1; a0 = 5'd7; d0 = 32'h0BADC0DE;
    v1 = 1'b0;
    reset = 1'b0;
    #1;
    check("noinit reset req0_ready", 32'(rdy0B), 32'd0);
    check("noinit reset init_done", 32'(initDoneB), 32'd1);
    check("noinit reset regWrite", 32'(regWriteB), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("noinit req0_ready", 32'(rdy0B), 32'd1);
    check("noinit req1_ready", 32'(rdy1B), 32'd0);
    check("init req0_ready held", 32'(rdy0), 32'd0);
    @(posedge clk);
    #1;
    check("noinit regWrite", 32'(regWriteB), 32'd1);
    check("noinit writeReg", 32'(writeRegB), 32'd7);
    check("noinit writeData", writeDataB, 32'h0BADC0DE);
    check("noinit grant_id", 32'(grantIdB), 32'd0);
    check("noinit init_done", 32'(initDoneB), 32'd1);
    v0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of RegisterFile and shares it between two writeback requesters: requester 0 is ALU writeback, requester 1 is memory/load writeback.
- After reset, sequences a zero-fill of registers 1..2^ADDR_WIDTH-1, then arbitrates round-robin with valid/ready handshakes.
- Sits between the pipeline writeback stage and RegisterFile. It drives regWrite/writeReg/writeData directly.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width (32 registers).
- INIT_ON_RESET, 1, 1 = run zero-fill sequence after reset; 0 = enter RUN directly.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU write request.
- req0_addr  in  ADDR_WIDTH  ALU destination register.
- req0_data  in  DATA_WIDTH  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid / req1_addr / req1_data / req1_ready  same as above, for the memory source.
- regWrite  out  1  RegisterFile write enable (registered).
- writeReg  out  ADDR_WIDTH  RegisterFile write address (registered).
- writeData  out  DATA_WIDTH  RegisterFile write data (registered).
- grant_id  out  1  source of the most recent accepted request.
- init_done  out  1  high once the zero-fill completes; stays high until reset.
- conflict_count  out  16  saturating count of RUN cycles with both requests valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: regWrite=0, writeReg=0, writeData=0, grant_id=0, conflict_count=0, init_done=0.
  - Internal: rr_ptr=0 (req0 preferred), cnt=1, state=INIT (RUN with init_done=1 if INIT_ON_RESET=0).
  - Both ready outputs are 0 while reset is asserted.
- Reset asserted mid-operation: the above values apply immediately. Any request in flight is dropped. The zero-fill restarts on release.
- States: INIT, RUN.
- INIT, each rising edge:
  - regWrite<=1, writeReg<=cnt, writeData<=0, cnt<=cnt+1.
  - When cnt==2^ADDR_WIDTH-1: state<=RUN and init_done<=1 on the same edge.
  - Result: writes to regs 1..31 appear in the 31 cycles after release. Register 0 is never written.
  - req0_ready=req1_ready=0 throughout INIT; valids are ignored.
- RUN, grant (combinational):
  - Only one valid: that source wins.
  - Both valid: rr_ptr selects the winner (0 -> req0, 1 -> req1).
  - reqN_ready = (state==RUN) & grantN. At most one ready is high per cycle. Ready does not depend on the requester's own ready.
- RUN, accept (valid & ready at edge):
  - writeReg<=addr, writeData<=data, grant_id<=winner, rr_ptr<=~winner.
  - regWrite<=(addr!=0). A write to register 0 is accepted and consumed but produces no write strobe.
- Latency: an accept in cycle N presents regWrite/writeReg/writeData during cycle N+1. Throughput is one write per cycle.
- No accept in RUN: regWrite<=0. writeReg, writeData and grant_id hold their values.
- Losing requester: must keep valid/addr/data stable until it receives ready. It is guaranteed a grant within 2 cycles while the other source streams.
- conflict_count: increments on every RUN edge with req0_valid & req1_valid. Saturates at 16'hFFFF. It does not count during INIT.
- Requests that are valid before init_done are not lost; they are accepted in RUN once granted.

Test Plan:
- Release reset with INIT_ON_RESET=1 and no requests -> 31 consecutive cycles with regWrite=1, writeReg=1..31, writeData=0. init_done rises with the writeReg=31 cycle. Both readys are 0 until RUN.
- In RUN, req0 only: addr=5, data=32'hDEADBEEF -> req0_ready=1 the same cycle. Next cycle: regWrite=1, writeReg=5, writeData=DEADBEEF, grant_id=0. The following cycle regWrite=0.
- Both valid and held for 4 cycles (req0 addr=1/data=A, req1 addr=2/data=B), rr_ptr=0 -> grants alternate 0,1,0,1. Each source is granted twice. conflict_count=4.
- req1 with addr=0, data=32'h12345678 -> req1_ready=1, grant_id=1, regWrite stays 0.
- Assert reset mid-stream, in the cycle after an accept -> regWrite, writeReg, writeData and init_done drop to 0 immediately. On release, INIT restarts from writeReg=1.
- INIT_ON_RESET=0: req0 valid in the first cycle after release -> accepted immediately, init_done=1 from reset.
